count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000, meaning clk cycles per count tick (1 kHz clk gives a 1 Hz tick); legal values are 2 or more.
REQ-002 The block SHALL have parameter DEB_CYC, default 20, meaning consecutive stable cycles needed to accept a change on st; legal values are 1 or more.
REQ-003 The block SHALL have parameter HOLD_TICKS, default 3, meaning ticks spent in HOLD before returning to IDLE; legal values are 1 or more.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 st  input  1  raw start push-button, asynchronous and bouncy, active-high.
REQ-007 num  output  3  digit code for the matrix display: 6 = "?" idle glyph, 5..0 = countdown digit.
REQ-008 running  output  1  high while in COUNT.
REQ-009 done  output  1  single-cycle pulse when the count reaches 0.

Function
REQ-010 st SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Debouncer: a counter SHALL clear whenever the synchronized st equals the debounced level (deb), and otherwise increment.
REQ-012 Debouncer: deb SHALL take the synchronized value on the cycle the counter reaches DEB_CYC, and the counter SHALL then clear.
REQ-013 Press detection: press SHALL be a one-cycle internal pulse, registered in the cycle after deb goes 0 to 1; a falling deb SHALL produce no event.
REQ-014 Prescaler: a counter of width clog2(TICK_DIV) SHALL run 0..TICK_DIV-1 and wrap, asserting tick for one cycle when it equals TICK_DIV-1.
REQ-015 Prescaler: it SHALL run only in COUNT and HOLD, and SHALL be held at 0 in IDLE.
REQ-016 FSM states SHALL be IDLE, COUNT and HOLD, with registered outputs.
REQ-017 IDLE: num=6, running=0; on press, go to COUNT with num=5 and prescaler cleared.
REQ-018 COUNT: on tick with num>0, num decrements by 1.
REQ-019 COUNT: on tick with num=1, num becomes 0, done pulses in that same cycle, and the next state is HOLD with the hold counter cleared.
REQ-020 COUNT: on press, restart with num=5 and prescaler cleared; press wins over a simultaneous tick.
REQ-021 HOLD: num=0, running=0; each tick increments the hold counter.
REQ-022 HOLD: when the hold counter reaches HOLD_TICKS, go to IDLE with num=6; press is ignored in HOLD.
REQ-023 num SHALL never take the value 7.
REQ-024 Undefined FSM encodings SHALL recover to IDLE on the next clk.
REQ-025 Latency: num changes in the cycle after the causing tick or press is sampled; done is coincident with num becoming 0.
REQ-026 Count duration: a full count from press to num=0 SHALL take exactly 5*TICK_DIV cycles.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, num=6, running=0, done=0, with synchronizer flops, deb, and all counters at 0.
REQ-028 rst asserted mid-COUNT or mid-HOLD SHALL abort with no done pulse.
REQ-029 After rst deasserts, st held high SHALL produce a press only after a fresh 0 to 1 transition of deb; a button held through reset starts nothing.

Verification (TICK_DIV=4, DEB_CYC=3, HOLD_TICKS=2)
REQ-030 Reset then idle 50 cycles -> num=6, running=0, done never high.
REQ-031 st bounces 1/0 every cycle for 10 cycles, then held high -> exactly one press, num=5 within 2+3+2 cycles of the stable level, running=1.
REQ-032 Full run -> num goes 5,4,3,2,1,0 at 4-cycle spacing; done high for exactly 1 cycle with num=0; 8 cycles later num=6.
REQ-033 Press during COUNT at num=2 -> num=5 next cycle and the next decrement 4 cycles later; a press coincident with a tick also gives num=5.
REQ-034 Press during HOLD -> ignored, num stays 0 until the return to IDLE.
REQ-035 rst pulse while num=3, with st held high -> num=6 immediately, no done pulse, no restart until st is released and pressed again.

Source files
------------

// File: rtl/count_ctrl.sv
// Start-button countdown controller: synchronizes and debounces a push-button,
// then counts 5..0 at one digit per prescaler tick, holds at 0, and returns to idle.
module count_ctrl #(
    parameter int TICK_DIV   = 1000,
    parameter int DEB_CYC    = 20,
    parameter int HOLD_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       st,
    output logic [2:0] num,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [2:0] NUM_IDLE  = 3'd6;
    localparam logic [2:0] NUM_START = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button front end: synchronizer, debouncer, rising-edge press pulse
    // ------------------------------------------------------------------
    logic [1:0]    sync_q;
    logic [1:0]    sync_vld;
    logic          st_s;
    logic [DW-1:0] deb_cnt;
    logic          deb;
    logic          deb_prev;
    logic          armed;
    logic          press;

    assign st_s = sync_q[1];

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            sync_vld <= '0;
        end else begin
            sync_q   <= {sync_q[0], st};
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt <= '0;
            deb     <= 1'b0;
        end else if (st_s == deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
            deb     <= st_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    // armed is set only once a real (post-reset) low level has been seen, so a
    // button held through reset cannot masquerade as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_prev <= 1'b0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            deb_prev <= deb;
            armed    <= armed | (sync_vld[1] & ~st_s & ~deb);
            press    <= deb & ~deb_prev & armed;
        end
    end

    // ------------------------------------------------------------------
    // Countdown FSM with prescaler and hold counter
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nx;
    logic [2:0]    num_nx;
    logic          running_nx;
    logic          done_nx;
    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] pre_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic          tick;

    assign tick = (state != IDLE) && (pre_cnt == PW'(TICK_DIV - 1));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        num_nx     = num;
        running_nx = running;
        done_nx    = 1'b0;
        pre_nx     = tick ? '0 : pre_cnt + PW'(1);
        hold_nx    = hold_cnt;

        case (state)
            IDLE: begin
                num_nx     = NUM_IDLE;
                running_nx = 1'b0;
                pre_nx     = '0;
                if (press) begin
                    state_nx   = COUNT;
                    num_nx     = NUM_START;
                    running_nx = 1'b1;
                end
            end

            COUNT: begin
                running_nx = 1'b1;
                if (press) begin
                    num_nx = NUM_START;
                    pre_nx = '0;
                end else if (tick) begin
                    if (num <= 3'd1) begin
                        state_nx   = HOLD;
                        num_nx     = 3'd0;
                        running_nx = 1'b0;
                        done_nx    = 1'b1;
                        hold_nx    = '0;
                    end else begin
                        num_nx = num - 3'd1;
                    end
                end
            end

            HOLD: begin
                num_nx     = 3'd0;
                running_nx = 1'b0;
                if (tick) begin
                    if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                        state_nx = IDLE;
                        num_nx   = NUM_IDLE;
                        pre_nx   = '0;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_cnt + HW'(1);
                    end
                end
            end

            default: begin
                state_nx   = IDLE;
                num_nx     = NUM_IDLE;
                running_nx = 1'b0;
                pre_nx     = '0;
                hold_nx    = '0;
            end
        endcase
    end

    // NOTE: reset is asynchronous, so outputs go to their idle values the
    // moment rst rises rather than waiting for the next clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            num      <= NUM_IDLE;
            running  <= 1'b0;
            done     <= 1'b0;
            pre_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            num      <= num_nx;
            running  <= running_nx;
            done     <= done_nx;
            pre_cnt  <= pre_nx;
            hold_cnt <= hold_nx;
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: vector table, hand-written corner cases and
// randomized button activity against a time-since-press reference model.
module tb_count_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int HT = 2;
    localparam int COUNT_LEN = 5 * TD;
    localparam int RUN_LEN   = (5 + HT) * TD;

    logic       clk = 1'b0;
    logic       rst;
    logic       st;
    logic [2:0] num;
    logic       running;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    count_ctrl #(
        .TICK_DIV  (TD),
        .DEB_CYC   (DB),
        .HOLD_TICKS(HT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .st     (st),
        .num    (num),
        .running(running),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model. The countdown is described purely by m_el, the number of
    // cycles since the last accepted press (-1 = idle): the digit is derived from
    // it with division, HOLD is the window after COUNT_LEN, idle after RUN_LEN.
    int m_el;
    bit m_done, m_press, m_deb, m_deb_prev, m_armed;
    int n_edge;
    bit s_hist[$];
    bit ss_hist[$];

    function automatic void model_reset();
        m_el = -1;
        m_done = 0; m_press = 0; m_deb = 0; m_deb_prev = 0; m_armed = 0;
        n_edge = 0;
        s_hist.delete();
        ss_hist.delete();
    endfunction

    function automatic void model_edge(input bit st_v);
        bit press_o = m_press;
        bit deb_o   = m_deb;
        bit prev_o  = m_deb_prev;
        bit armed_o = m_armed;
        bit st_s;
        bit all_diff;

        if (press_o && m_el < COUNT_LEN) m_el = 0;
        else if (m_el >= 0) begin
            m_el++;
            if (m_el == RUN_LEN) m_el = -1;
        end
        m_done = (m_el == COUNT_LEN);

        m_press    = deb_o && !prev_o && armed_o;
        m_deb_prev = deb_o;

        // Synchronized level is the raw sample from two edges back (0 before that).
        n_edge++;
        s_hist.push_back(st_v);
        if (s_hist.size() > 3) void'(s_hist.pop_front());
        st_s = (n_edge >= 3) ? s_hist[0] : 1'b0;
        if (n_edge >= 3 && !st_s && !deb_o) m_armed = 1;

        // Accept a new level once the last DB synchronized samples all differ.
        ss_hist.push_back(st_s);
        if (ss_hist.size() > DB) void'(ss_hist.pop_front());
        all_diff = (ss_hist.size() == DB);
        foreach (ss_hist[i]) if (ss_hist[i] == deb_o) all_diff = 0;
        if (all_diff) m_deb = st_s;
    endfunction

    function automatic logic [4:0] model_out();
        logic [2:0] n;
        logic       r;
        if (m_el < 0)              n = 3'd6;
        else if (m_el < COUNT_LEN) n = 3'(5 - m_el / TD);
        else                       n = 3'd0;
        r = (m_el >= 0) && (m_el < COUNT_LEN);
        return {n, r, m_done};
    endfunction

    // One clock cycle: drive st, let the edge happen, compare on the falling edge.
    task automatic step(input logic v);
        st = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check("cycle_outputs", {num, running, done}, model_out());
    endtask

    task automatic steps(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic run_until(input logic v, input int target, input int budget, input string name);
        int n = 0;
        while (m_el != target && n < budget) begin
            step(v);
            n++;
        end
        check(name, m_el, target);
    endtask

    task automatic do_reset(input logic v);
        st  = v;
        rst = 1'b1;
        model_reset();
        #1;
        check("reset_outputs", {num, running, done}, {3'd6, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       st;
        int         cycles;
        logic [2:0] num;
        logic       running;
        logic       done;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int  n;
        bit  got;
        logic lvl;
        int  len;

        vecs[0]  = '{1'b0, 50, 3'd6, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 6,  3'd6, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1,  3'd5, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4,  3'd4, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4,  3'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4,  3'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4,  3'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 3,  3'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1,  3'd0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1,  3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 6,  3'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1,  3'd6, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 10, 3'd6, 1'b0, 1'b0};

        rst = 1'b0;
        st  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        // Idle, clean press, full countdown, hold and return to idle.
        foreach (vecs[i]) begin
            steps(vecs[i].st, vecs[i].cycles);
            check($sformatf("vec%0d", i), {num, running, done},
                  {vecs[i].num, vecs[i].running, vecs[i].done});
        end

        // Bouncing button: one press, digit 5 within 2+3+2 cycles of the stable level.
        for (int i = 0; i < 10; i++) step(i % 2 == 0);
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            step(1'b1);
            n++;
            if (num == 3'd5) got = 1;
        end
        check("bounce_press_latency", {got, n <= 7}, 2'b11);
        check("bounce_running", running, 1'b1);
        run_until(1'b0, -1, 60, "bounce_run_idle");

        // Restart from digit 2, then a restart landing on a tick edge.
        run_until(1'b1, 0, 20, "press_b");
        run_until(1'b0, 7, 20, "release_b");
        run_until(1'b1, 13, 20, "raise_b");
        check("num_before_restart", num, 3'd2);
        step(1'b1);
        check("restart_at_2", num, 3'd5);
        steps(1'b1, 3);
        check("restart_hold_5", num, 3'd5);
        step(1'b1);
        check("restart_next_dec", num, 3'd4);
        run_until(1'b0, 9, 20, "release_c");
        run_until(1'b1, 15, 20, "raise_c");
        check("num_before_tick_press", num, 3'd2);
        step(1'b1);
        check("press_on_tick", num, 3'd5);
        steps(1'b1, 4);
        check("press_on_tick_dec", num, 3'd4);

        // Press during HOLD is ignored.
        run_until(1'b0, 16, 30, "release_d");
        run_until(1'b1, 26, 20, "hold_press");
        check("hold_ignores_press", {num, running}, {3'd0, 1'b0});
        run_until(1'b1, -1, 10, "hold_exit");
        check("hold_exit_idle", num, 3'd6);
        steps(1'b1, 20);
        check("held_after_hold_no_press", num, 3'd6);

        // Reset mid-count with the button held: abort, no restart until re-pressed.
        steps(1'b0, 10);
        run_until(1'b1, 8, 30, "press_e");
        check("num_before_reset", num, 3'd3);
        do_reset(1'b1);
        steps(1'b1, 40);
        check("held_through_reset", {num, running}, {3'd6, 1'b0});
        steps(1'b0, 10);
        run_until(1'b1, 0, 20, "repress_e");
        check("repress_after_reset", {num, running}, {3'd5, 1'b1});

        // Randomized button activity with occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < len; i++) step(1'($urandom_range(0, 1)));
            end else begin
                steps(lvl, len);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
